// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: bus between the truth-table sweeper and its environment.
// start/abort request or cancel a sweep, f_in is the response of the function under test,
// w/x/y/z drive that function, busy/done report progress, and table_out/mismatch_cnt/match
// carry the result of the last sweep.
`timescale 1ns/1ps
interface truth_table_sweeper_if;
   logic        start;
   logic        abort;
   logic        f_in;
   logic        w;
   logic        x;
   logic        y;
   logic        z;
   logic        busy;
   logic        done;
   logic [15:0] table_out;
   logic [4:0]  mismatch_cnt;
   logic        match;
   modport master (
      output start, abort, f_in,
      input  w, x, y, z, busy, done, table_out, mismatch_cnt, match
   );
   modport slave (
      input  start, abort, f_in,
      output w, x, y, z, busy, done, table_out, mismatch_cnt, match
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 vectors {w,x,y,z} into a 4-input function, holds each
// for SETTLE cycles, captures f_in into table_out and counts differences from EXPECTED.
// Ports: clk (rising-edge clock), rst_n (asynchronous active-low reset),
//        bus (slave side: start/abort/f_in in; w/x/y/z, busy, done, table_out,
//        mismatch_cnt, match out).
`timescale 1ns/1ps
module truth_table_sweeper #(
   parameter int          SETTLE   = 1,
   parameter logic [15:0] EXPECTED = 16'h1F55
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;
   state_t      state, state_nxt;
   logic [3:0]  idx;
   logic [3:0]  cnt;
   logic [15:0] tbl;
   logic [4:0]  mis;
   logic [4:0]  mis_nxt;
   logic        match_q;
   logic        sample;
   // The last cycle of each vector's settle window; abort takes priority over sampling.
   assign sample  = state == SWEEP && !bus.abort && cnt == 4'(SETTLE - 1);
   assign mis_nxt = (bus.f_in != EXPECTED[idx] && mis != 5'd16) ? mis + 5'd1 : mis;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = bus.start ? SWEEP : IDLE;
         SWEEP:   state_nxt = bus.abort ? IDLE : (sample && idx == 4'hF) ? FIN : SWEEP;
         default: state_nxt = IDLE;
      endcase
   end
   // idx doubles as the registered stimulus; it is returned to 0 whenever the sweep
   // ends (wrap after vector 15, or abort) so the outputs read 0 outside SWEEP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         cnt     <= '0;
         tbl     <= '0;
         mis     <= '0;
         match_q <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         idx     <= '0;
         cnt     <= '0;
         tbl     <= '0;
         mis     <= '0;
         match_q <= 1'b0;
      end else if (state == SWEEP) begin
         if (bus.abort) begin
            idx <= '0;
            cnt <= '0;
         end else if (sample) begin
            tbl[idx] <= bus.f_in;
            mis      <= mis_nxt;
            cnt      <= '0;
            idx      <= idx + 4'd1;
            if (idx == 4'hF) match_q <= mis_nxt == 5'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end
   assign {bus.w, bus.x, bus.y, bus.z} = idx;
   assign bus.busy         = state == SWEEP;
   assign bus.done         = state == FIN;
   assign bus.table_out    = tbl;
   assign bus.mismatch_cnt = mis;
   assign bus.match        = match_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for truth_table_sweeper with NAND/NOR/constant/
// inverted/random functions under test, abort, reset and a SETTLE=3 instance.
`timescale 1ns/1ps
module tb_truth_table_sweeper;
   localparam logic [15:0] EXP = 16'h1F55;
   typedef struct {
      logic [15:0] tbl;
      logic [4:0]  mis;
      logic        m;
   } exp_t;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   int          errors = 0;
   int          checks = 0;
   int          mode   = 0;
   logic [15:0] tt     = '0;
   exp_t        q[$];
   always #5 clk = ~clk;
   truth_table_sweeper_if bus ();
   truth_table_sweeper_if bus3 ();
   truth_table_sweeper #(.SETTLE(1), .EXPECTED(EXP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   truth_table_sweeper #(.SETTLE(3), .EXPECTED(EXP)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   // F = 1 on vectors {0,2,4,6,8,9,10,11,12}, built two ways from gate-level forms.
   function automatic logic f_nand(input logic [3:0] v);
      logic w, x, y, z;
      {w, x, y, z} = v;
      return ~(~(~z & ~(w & y)) & ~(w & ~x));
   endfunction
   function automatic logic f_nor(input logic [3:0] v);
      logic w, x, y, z;
      {w, x, y, z} = v;
      return ~(~(w | ~z) | ~(~w | ~x | ~z) | ~(~w | ~x | ~y));
   endfunction
   function automatic logic fval(input int md, input logic [15:0] t, input logic [3:0] v);
      case (md)
         0:       return f_nand(v);
         1:       return f_nor(v);
         2:       return 1'b0;
         3:       return ~f_nand(v);
         default: return t[v];
      endcase
   endfunction
   assign bus.f_in   = fval(mode, tt, {bus.w, bus.x, bus.y, bus.z});
   assign bus3.f_in  = f_nand({bus3.w, bus3.x, bus3.y, bus3.z});
   assign bus3.abort = 1'b0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         if (q.size() == 0) check("unexpected_done", 32'(bus.done), 32'd0);
         else begin
            e = q.pop_front();
            check("table_out", 32'(bus.table_out), 32'(e.tbl));
            check("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(e.mis));
            check("match", 32'(bus.match), 32'(e.m));
         end
      end
   end
   task automatic run_sweep(input int md, input bit with_abort, input bit rand_start);
      exp_t        e;
      logic [15:0] t;
      int          n, bad;
      mode = md;
      for (int v = 0; v < 16; v++) t[v] = fval(md, tt, 4'(v));
      e.tbl = t;
      e.mis = 5'($countones(t ^ EXP));
      e.m   = (t == EXP);
      q.push_back(e);
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = with_abort;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
      n   = 0;
      bad = 0;
      while (!bus.done && n < 100) begin
         if ({bus.w, bus.x, bus.y, bus.z} != 4'(n) || !bus.busy) bad++;
         if (rand_start) bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      check("sweep_len", 32'(n), 32'd16);
      check("vector_seq", 32'(bad), 32'd0);
      check("fin_outputs", 32'({bus.busy, bus.w, bus.x, bus.y, bus.z}), 32'd0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      check("fin_ignores_start", 32'(bus.busy), 32'd0);
      bus.start = 1'b0;
   endtask
   task automatic start_and_reach(input int vec);
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while ({bus.w, bus.x, bus.y, bus.z} != 4'(vec) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_vector", 32'({bus.w, bus.x, bus.y, bus.z}), 32'(vec));
   endtask
   initial begin
      int n, bad;
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus3.start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_state", 32'({bus.w, bus.x, bus.y, bus.z, bus.busy, bus.done,
                                 bus.match, bus.mismatch_cnt, bus.table_out}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_sweep(0, 1'b0, 1'b0);
      run_sweep(1, 1'b0, 1'b1);
      run_sweep(2, 1'b0, 1'b0);
      run_sweep(3, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tt = (i == 3) ? EXP : 16'($urandom);
         run_sweep(4, i == 0, 1'b1);
      end
      // abort while vector 5 is on the outputs
      mode = 4;
      tt   = 16'($urandom);
      start_and_reach(5);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check("abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
      check("abort_match", 32'(bus.match), 32'd0);
      check("abort_table", 32'(bus.table_out), 32'({11'd0, tt[4:0]}));
      check("abort_mismatch", 32'(bus.mismatch_cnt), 32'($countones((tt ^ EXP) & 16'h001F)));
      repeat (4) @(posedge clk);
      run_sweep(0, 1'b0, 1'b0);
      // SETTLE=3 instance
      @(negedge clk);
      bus3.start = 1'b1;
      @(posedge clk); #1;
      bus3.start = 1'b0;
      n   = 0;
      bad = 0;
      while (!bus3.done && n < 200) begin
         if ({bus3.w, bus3.x, bus3.y, bus3.z} != 4'(n / 3)) bad++;
         @(posedge clk); #1;
         n++;
      end
      check("s3_len", 32'(n), 32'd48);
      check("s3_hold", 32'(bad), 32'd0);
      check("s3_table", 32'(bus3.table_out), 32'(EXP));
      check("s3_result", 32'({bus3.mismatch_cnt, bus3.match}), 32'({5'd0, 1'b1}));
      repeat (2) @(posedge clk);
      // reset during vector 9
      mode = 0;
      start_and_reach(9);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", 32'({bus.w, bus.x, bus.y, bus.z, bus.busy, bus.done,
                                      bus.match, bus.mismatch_cnt, bus.table_out}), 32'd0);
      check("midreset_s3", 32'({bus3.match, bus3.mismatch_cnt, bus3.table_out}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      run_sweep(0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE, default 1, meaning: cycles each input vector is held before f_in is sampled; legal range 1..15.
REQ-002 Parameter EXPECTED, default 16'h1F55, meaning: golden truth table; bit i is the expected F for {w,x,y,z}=i.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a running sweep.
REQ-007 f_in  input  1  F output of the 4-input function under test.
REQ-008 w, x, y, z  output  1 each  stimulus to the function under test; w is the MSB of the vector index.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 table_out  output  16  captured truth table; bit i is f_in sampled for vector i.
REQ-012 mismatch_cnt  output  5  number of bits where table_out differs from EXPECTED, range 0..16.
REQ-013 match  output  1  high when the last completed sweep had zero mismatches.

Function
REQ-014 The FSM SHALL have states IDLE, SWEEP and FIN.
REQ-015 IDLE: {w,x,y,z}=0, busy=0, done=0; table_out, mismatch_cnt and match hold their last values.
REQ-016 IDLE->SWEEP: start=1 at edge k SHALL do all of the following at that edge:
- clear table_out, mismatch_cnt and match to 0;
- set index to 0 and settle counter to 0;
- set busy=1.
REQ-017 In SWEEP, {w,x,y,z} SHALL equal the 4-bit index, registered, with no glitch between vectors.
REQ-018 The settle counter SHALL count 0..SETTLE-1; on the edge where it equals SETTLE-1:
- f_in is written into table_out[index];
- mismatch_cnt increments by 1 if f_in != EXPECTED[index];
- the counter resets to 0.
REQ-019 At that same edge, if index < 15, the index SHALL increment; if index = 15, the FSM goes to FIN and the index wraps to 0.
REQ-020 Each vector SHALL be driven for exactly SETTLE cycles; the last sample SHALL occur at edge k+16*SETTLE.
REQ-021 FIN SHALL last exactly one cycle with:
- done=1, busy=0, {w,x,y,z}=0;
- match = (mismatch_cnt == 0), registered on the edge entering FIN;
- the next state is IDLE.
REQ-022 start SHALL be ignored in SWEEP and in FIN; a new sweep can begin no earlier than the first IDLE cycle.
REQ-023 abort=1 in SWEEP SHALL force IDLE at the next edge; done does not pulse, match is 0, and table_out/mismatch_cnt hold their partial values.
REQ-024 abort SHALL have no effect in IDLE or FIN; if abort and start are both high in IDLE, start wins.
REQ-025 mismatch_cnt SHALL saturate at 16; it cannot exceed 16 by construction and SHALL never wrap.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold immediately, independent of clk:
- state=IDLE;
- index=0 and settle counter=0;
- {w,x,y,z}=0, busy=0, done=0;
- table_out=16'h0000, mismatch_cnt=0, match=0.
REQ-027 Reset asserted mid-sweep SHALL discard the sweep with no done pulse.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-029 SETTLE=1, f_in driven by the NAND implementation of F, start pulsed at edge k -> busy for 16 cycles, done at cycle k+17, table_out=16'h1F55, mismatch_cnt=0, match=1.
REQ-030 Same sweep with f_in driven by the NOR implementation -> table_out=16'h1F55, match=1; this confirms the two forms are equivalent.
REQ-031 f_in tied 0 -> table_out=16'h0000, mismatch_cnt=9, match=0; f_in driven by ~F -> table_out=16'hE0AA, mismatch_cnt=16, match=0.
REQ-032 SETTLE=3, start at edge k -> each vector held 3 cycles, last sample at edge k+48, done pulse on cycle k+49.
REQ-033 start re-pulsed during SWEEP -> no restart and identical results; abort while {w,x,y,z}=5 -> busy=0 next cycle, no done, match=0, bits 0..4 of table_out valid; a following start gives a full correct sweep.
REQ-034 rst_n pulsed low during vector 9 -> all outputs 0 immediately, no done; a subsequent sweep gives 16'h1F55 with match=1.
